// File: rtl/dfp_write_buffer.sv
// dfp_write_buffer: write-back buffer between the D-cache and the cache arbiter.
// Dirty-line writebacks are acknowledged after one cycle and parked in a small
// FIFO. Repeat writes to a buffered line are merged in place. Entries drain
// downstream whenever no line fill needs the arbiter.
// Build option WB_FORWARD_EN: a fill that hits a buffered line is answered
// directly from the buffer. When the option is off, matching entries are
// drained first and the fill then goes downstream.
module dfp_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ufp_addr,
    input  logic              ufp_read,
    input  logic              ufp_write,
    input  logic [255:0]      ufp_wdata,
    output logic [255:0]      ufp_rdata,
    output logic [ADDR_W-1:0] ufp_raddr,
    output logic              ufp_resp,
    output logic [ADDR_W-1:0] dfp_addr,
    output logic              dfp_read,
    output logic              dfp_write,
    output logic [255:0]      dfp_wdata,
    input  logic [255:0]      dfp_rdata,
    input  logic [ADDR_W-1:0] dfp_raddr,
    input  logic              dfp_resp,
    output logic              full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TAG_W = ADDR_W - 5;

    typedef enum logic [1:0] {IDLE, RD_WAIT, DR_WAIT, FWD} state_t;

    state_t            state_reg;
    logic [DEPTH-1:0]  valid_reg;
    logic [TAG_W-1:0]  tag_reg [DEPTH];
    logic [255:0]      data_mem [DEPTH];
    logic [PTR_W-1:0]  head_reg;
    logic [PTR_W-1:0]  tail_reg;
    logic [CNT_W-1:0]  count_reg;

    logic              ufp_resp_reg;
    logic [255:0]      ufp_rdata_reg;
    logic [ADDR_W-1:0] ufp_raddr_reg;
    logic [ADDR_W-1:0] dfp_addr_reg;
    logic              dfp_read_reg;
    logic              dfp_write_reg;
    logic [255:0]      dfp_wdata_reg;

    logic [TAG_W-1:0]  req_tag;
    logic [DEPTH-1:0]  match_vec;
    logic              hit;
    logic [PTR_W-1:0]  hit_idx;
    logic              wr_req;
    logic              rd_req;
    logic              head_busy;
    logic              wr_coalesce;
    logic              wr_enqueue;
    logic              wr_accept;
    logic              drain_pop;
    logic [PTR_W-1:0]  wr_idx;
    logic              unused_bits;

    // Offset bits of line addresses carry no information here.
    assign unused_bits = ^{ufp_addr[4:0], dfp_raddr[4:0]};

    assign req_tag = ufp_addr[ADDR_W-1:5];

    // One comparator per entry against the current request's line address.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match_vec[gi] = valid_reg[gi] && (tag_reg[gi] == req_tag);
        end
    endgenerate

    // Coalescing keeps tags unique, so at most one entry matches; encode its index.
    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match_vec[i]) hit_idx = PTR_W'(i);
        end
    end

    assign hit = |match_vec;
    assign full = (count_reg == CNT_W'(DEPTH));

    // A request is ignored while its own response is on ufp_resp.
    // Writes are taken only when no fill is being served.
    assign wr_req    = ufp_write && !ufp_resp_reg && (state_reg == IDLE || state_reg == DR_WAIT);
    assign rd_req    = ufp_read && !ufp_write && !ufp_resp_reg && (state_reg == IDLE);
    // The head line is in flight downstream, so its data must not change under the arbiter.
    assign head_busy   = (state_reg == DR_WAIT) && (hit_idx == head_reg);
    assign wr_coalesce = wr_req && hit && !head_busy;
    assign wr_enqueue  = wr_req && !hit && !full;
    assign wr_accept   = wr_coalesce || wr_enqueue;
    assign drain_pop   = (state_reg == DR_WAIT) && dfp_resp;
    assign wr_idx      = hit ? hit_idx : tail_reg;

    // Line data storage: one write port fed by accepted writebacks.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) data_mem[wr_idx] <= ufp_wdata;
    end

    // Queue bookkeeping, FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            valid_reg     <= '0;
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            ufp_resp_reg  <= 1'b0;
            ufp_rdata_reg <= '0;
            ufp_raddr_reg <= '0;
            dfp_addr_reg  <= '0;
            dfp_read_reg  <= 1'b0;
            dfp_write_reg <= 1'b0;
            dfp_wdata_reg <= '0;
            for (int i = 0; i < DEPTH; i++) tag_reg[i] <= '0;
        end else begin
            ufp_resp_reg <= wr_accept;

            if (wr_enqueue) begin
                valid_reg[tail_reg] <= 1'b1;
                tag_reg[tail_reg]   <= req_tag;
                tail_reg            <= tail_reg + PTR_W'(1);
            end
            if (drain_pop) begin
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= head_reg + PTR_W'(1);
            end
            case ({wr_enqueue, drain_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase

            case (state_reg)
                IDLE: begin
                    if (rd_req && !hit) begin
                        state_reg    <= RD_WAIT;
                        dfp_read_reg <= 1'b1;
                        dfp_addr_reg <= {req_tag, 5'b0};
                    end
`ifdef WB_FORWARD_EN
                    else if (rd_req && hit) begin
                        state_reg     <= FWD;
                        ufp_rdata_reg <= data_mem[hit_idx];
                        ufp_raddr_reg <= {req_tag, 5'b0};
                        ufp_resp_reg  <= 1'b1;
                    end
`endif
                    // Hold off draining while a response is on ufp, so a
                    // follow-up request from the cache gets the first look.
                    else if (count_reg != '0 && !ufp_resp_reg && !wr_accept) begin
                        state_reg     <= DR_WAIT;
                        dfp_write_reg <= 1'b1;
                        dfp_addr_reg  <= {tag_reg[head_reg], 5'b0};
                        dfp_wdata_reg <= data_mem[head_reg];
                    end
                end
                RD_WAIT: begin
                    if (dfp_resp) begin
                        state_reg     <= IDLE;
                        dfp_read_reg  <= 1'b0;
                        ufp_rdata_reg <= dfp_rdata;
                        ufp_raddr_reg <= {dfp_raddr[ADDR_W-1:5], 5'b0};
                        ufp_resp_reg  <= 1'b1;
                    end
                end
                DR_WAIT: begin
                    if (dfp_resp) begin
                        state_reg     <= IDLE;
                        dfp_write_reg <= 1'b0;
                    end
                end
                FWD:     state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ufp_resp  = ufp_resp_reg;
    assign ufp_rdata = ufp_rdata_reg;
    assign ufp_raddr = ufp_raddr_reg;
    assign dfp_addr  = dfp_addr_reg;
    assign dfp_read  = dfp_read_reg;
    assign dfp_write = dfp_write_reg;
    assign dfp_wdata = dfp_wdata_reg;

endmodule

// File: doc/dfp_write_buffer.md
DFP_WRITE_BUFFER -- requirements
Module: dfp_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of 256-bit line entries (power of two, 2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning byte address width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have port ufp_addr  input  32  meaning the D-cache line address; bits [4:0] are ignored.
REQ-006 SHALL have port ufp_read  input  1  meaning a D-cache line-fill request, held until ufp_resp.
REQ-007 SHALL have port ufp_write  input  1  meaning a D-cache dirty-line writeback request, held until ufp_resp.
REQ-008 SHALL have port ufp_wdata  input  256  meaning the writeback line data.
REQ-009 SHALL have ports ufp_rdata  output  256, ufp_raddr  output  32 and ufp_resp  output  1, meaning fill data, fill address and a one-cycle completion pulse.
REQ-010 SHALL have ports dfp_addr  output  32, dfp_read  output  1, dfp_write  output  1 and dfp_wdata  output  256, meaning the request toward the cache arbiter.
REQ-011 SHALL have ports dfp_rdata  input  256, dfp_raddr  input  32 and dfp_resp  input  1, meaning the arbiter response.
REQ-012 SHALL have port full  output  1, meaning all DEPTH entries are valid.

Function
REQ-013 SHALL hold writebacks in a FIFO of {valid, line address [31:5], data} entries, with wrapping head/tail pointers and a count of 0..DEPTH.
REQ-014 SHALL, for a write accepted while not full, pulse ufp_resp exactly one cycle after ufp_write is first sampled high (1-cycle latency) and enqueue the entry at tail.
REQ-015 SHALL coalesce a write whose line address matches a valid entry by overwriting that entry's data in place; count is unchanged and the response latency is the same as REQ-014.
REQ-016 SHALL, when full and a write does not coalesce, withhold ufp_resp until a drain completes; the write is then accepted in the cycle following that dfp_resp.
REQ-017 SHALL ignore ufp_read/ufp_write in the cycle ufp_resp is high, so a held request is never serviced twice.
REQ-018 SHALL, if ufp_read and ufp_write are both high, service the write first.
REQ-019 SHALL implement FSM states IDLE, RD_WAIT, DR_WAIT and FWD.
REQ-020 IDLE -> RD_WAIT: a read that misses the buffer is issued downstream, taking priority over draining.
REQ-021 IDLE -> DR_WAIT: with no eligible read and count>0, the head entry is issued with dfp_write.
REQ-022 IDLE -> FWD: a read that hits the buffer (see REQ-031/032).
REQ-023 RD_WAIT -> IDLE on dfp_resp; ufp_rdata/ufp_raddr are registered from dfp_rdata/dfp_raddr and ufp_resp pulses the next cycle.
REQ-024 DR_WAIT -> IDLE on dfp_resp; the head entry is popped.
REQ-025 SHALL hold dfp_read/dfp_write high, with dfp_addr and dfp_wdata stable, from issue until dfp_resp is sampled, deasserting them the cycle after; at most one is high at a time.
REQ-026 SHALL drive dfp_addr[4:0] and ufp_raddr[4:0] as zero.
REQ-027 SHALL, when a coalescing write targets the head entry during DR_WAIT, stall that write until dfp_resp so the in-flight data is not modified.
REQ-028 SHALL compute full and count from registered state only; full is asserted the cycle after the DEPTH-th entry is enqueued.

Reset
REQ-029 SHALL, on rst sampled high, clear all valid bits, pointers and count and enter IDLE; from the next cycle dfp_read=0, dfp_write=0, ufp_resp=0, full=0, dfp_addr=0, dfp_wdata=0, ufp_rdata=0 and ufp_raddr=0.
REQ-030 SHALL discard buffered and in-flight transactions on reset mid-operation; a dfp_resp arriving after reset is ignored.

Configuration
REQ-031 With macro WB_FORWARD_EN defined, a read hitting a valid entry SHALL go to FWD, return that entry's data and address with ufp_resp one cycle later and make no downstream request, then return to IDLE.
REQ-032 Without WB_FORWARD_EN, a read hitting a valid entry SHALL drain entries in FIFO order (DR_WAIT loops) until no entry matches, then issue the read downstream (RD_WAIT); FWD is unreachable.

Verification
REQ-033 Reset, then write 0x1000 with data A -> ufp_resp pulses 1 cycle later; dfp_write issued next at 0x1000 with A; count returns to 0 after dfp_resp.
REQ-034 Four writes to 0x0, 0x20, 0x40 and 0x60 with dfp_resp held low -> full=1; a fifth write to 0x80 gets no ufp_resp until the first dfp_resp, then is accepted.
REQ-035 Write 0x20 with A then 0x20 with B before any drain -> count=1; the single drain carries B.
REQ-036 WB_FORWARD_EN defined, write 0x40 with C then read 0x40 -> ufp_rdata=C and ufp_raddr=0x40 one cycle later, with no dfp_read issued.
REQ-037 WB_FORWARD_EN undefined, same stimulus as REQ-036 -> dfp_write 0x40 completes before dfp_read 0x40 is issued; ufp_rdata equals dfp_rdata.
REQ-038 Assert rst during DR_WAIT with count=3 -> next cycle dfp_write=0 and full=0; a late dfp_resp causes no pop and no ufp_resp.
